// File: rtl/clk_monitor_sel.sv
// Clock activity monitor: counts edges of divided-down source toggles per window,
// declares channels alive, and selects the lowest-index alive channel with guard blanking.
module clk_monitor_ch #(
   parameter int CNT_W     = 16,
   parameter int MIN_EDGES = 4,
   parameter int MAX_EDGES = (1 << CNT_W) - 2,
   parameter int GOOD_WIN  = 2
) (
   input  logic             local_clk,
   input  logic             rst,
   input  logic             tgl,
   input  logic             win_end,
   output logic [CNT_W-1:0] edge_cnt,
   output logic             alive
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_EDGES);
   localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_EDGES);
   localparam logic [3:0]       GOOD_C  = 4'(GOOD_WIN);

   // sync[1:0] is the two-flop synchronizer, sync[2] the delayed copy
   logic [2:0]       sync;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_fin;
   logic [3:0]       run;
   logic             edge_det;
   logic             good;

   assign edge_det = sync[1] ^ sync[2];
   assign cnt_fin  = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(edge_det);
   assign good     = (cnt_fin != CNT_MAX) && (cnt_fin >= MIN_C) && (cnt_fin <= MAX_C);

   always_ff @(posedge local_clk) begin
      if (rst) begin
         sync     <= '0;
         cnt      <= '0;
         edge_cnt <= '0;
         run      <= '0;
         alive    <= 1'b0;
      end else begin
         sync <= {sync[1:0], tgl};
         if (win_end) begin
            edge_cnt <= cnt_fin;
            cnt      <= '0;
            if (good) begin
               run   <= (run >= GOOD_C) ? GOOD_C : run + 4'd1;
               alive <= (run >= GOOD_C - 4'd1);
            end else begin
               run   <= '0;
               alive <= 1'b0;
            end
         end else begin
            cnt <= cnt_fin;
         end
      end
   end
endmodule

module clk_monitor_sel #(
   parameter int N_CH      = 2,
   parameter int WIN_LOG2  = 16,
   parameter int CNT_W     = 16,
   parameter int MIN_EDGES = 4,
   parameter int MAX_EDGES = (1 << CNT_W) - 2,
   parameter int GOOD_WIN  = 2,
   parameter int GUARD     = 16
) (
   input  logic                  local_clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       mon_tgl,
   output logic [N_CH-1:0]       alive,
   output logic [2:0]            sel,
   output logic                  sel_valid,
   output logic                  sel_chg,
   output logic [N_CH*CNT_W-1:0] edge_cnt
);
   typedef enum logic [1:0] {S_NONE, S_LOCKED, S_GUARD} state_t;

   localparam logic [7:0] GUARD_C = 8'(GUARD - 1);

   state_t              state;
   logic [WIN_LOG2-1:0] win_cnt;
   logic [7:0]          gcnt;
   logic [2:0]          pref;
   logic                any_alive;
   logic                win_end;

   assign win_end   = &win_cnt;
   assign any_alive = |alive;

   always_ff @(posedge local_clk) begin
      if (rst) win_cnt <= '0;
      else     win_cnt <= win_cnt + 1'b1;
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      clk_monitor_ch #(
         .CNT_W(CNT_W), .MIN_EDGES(MIN_EDGES), .MAX_EDGES(MAX_EDGES), .GOOD_WIN(GOOD_WIN)
      ) u_ch (
         .local_clk (local_clk),
         .rst       (rst),
         .tgl       (mon_tgl[i]),
         .win_end   (win_end),
         .edge_cnt  (edge_cnt[i*CNT_W +: CNT_W]),
         .alive     (alive[i])
      );
   end

   always_comb begin
      pref = 3'd0;
      for (int i = N_CH - 1; i >= 0; i--)
         if (alive[i]) pref = 3'(i);
   end

   // GUARD expiry falls through to the same rules as LOCKED, so a channel
   // that dies or is outranked during blanking switches without visiting NONE.
   always_ff @(posedge local_clk) begin
      if (rst) begin
         state     <= S_NONE;
         sel       <= '0;
         sel_valid <= 1'b0;
         sel_chg   <= 1'b0;
         gcnt      <= '0;
      end else begin
         sel_chg <= 1'b0;
         if (state == S_NONE) begin
            sel_valid <= 1'b0;
            if (any_alive) begin
               sel     <= pref;
               sel_chg <= 1'b1;
               gcnt    <= GUARD_C;
               state   <= S_GUARD;
            end
         end else if (state == S_GUARD && gcnt != 8'd0) begin
            gcnt <= gcnt - 8'd1;
         end else if (!any_alive) begin
            sel_chg   <= (sel != 3'd0);
            sel       <= '0;
            sel_valid <= 1'b0;
            state     <= S_NONE;
         end else if (pref != sel) begin
            sel       <= pref;
            sel_chg   <= 1'b1;
            sel_valid <= 1'b0;
            gcnt      <= GUARD_C;
            state     <= S_GUARD;
         end else begin
            sel_valid <= 1'b1;
            state     <= S_LOCKED;
         end
      end
   end
endmodule

// File: tb/tb_clk_monitor_sel.sv
// Bench for clk_monitor_sel: randomized toggle stimulus checked cycle by cycle against
// a window/edge-timeline reference model, plus scenario checks on timing and limits.
module tb_clk_monitor_sel;
   localparam int WIN = 256;
   localparam int GW  = 2;
   localparam int GD  = 16;
   localparam int MINE = 4;

   logic        local_clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  mon_tgl = 2'b00;
   logic [1:0]  alive, alive2;
   logic [2:0]  sel, sel2;
   logic        sel_valid, sel_chg, sel_valid2, sel_chg2;
   logic [31:0] edge_cnt;
   logic [7:0]  edge_cnt2;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 local_clk = ~local_clk;

   clk_monitor_sel #(.N_CH(2), .WIN_LOG2(8), .CNT_W(16), .MIN_EDGES(MINE), .GOOD_WIN(GW), .GUARD(GD)) dut (
      .local_clk(local_clk), .rst(rst), .mon_tgl(mon_tgl), .alive(alive), .sel(sel),
      .sel_valid(sel_valid), .sel_chg(sel_chg), .edge_cnt(edge_cnt));

   clk_monitor_sel #(.N_CH(2), .WIN_LOG2(8), .CNT_W(4), .MIN_EDGES(MINE), .GOOD_WIN(GW), .GUARD(GD)) dut_sat (
      .local_clk(local_clk), .rst(rst), .mon_tgl(mon_tgl), .alive(alive2), .sel(sel2),
      .sel_valid(sel_valid2), .sel_chg(sel_chg2), .edge_cnt(edge_cnt2));

   // ---------------- reference model: edge timeline binned into windows ----------------
   int         m_pos = 0;
   int         wcnt [0:255][0:1];
   logic [1:0] m_prev = 2'b00;
   int         run16 [0:1];
   int         run4 [0:1];
   logic [1:0] m_alive = 2'b00, m_alive2 = 2'b00;
   logic [15:0] m_ec [0:1];
   logic [3:0]  m_ec2 [0:1];
   int         m_state = 0;   // 0 none, 1 locked, 2 guard
   int         m_sel = 0;
   int         g_exp = 0;
   logic       m_valid = 1'b0, m_chg = 1'b0;
   logic [48:0] obs, expv;

   function automatic int lowest(input logic [1:0] a);
      for (int i = 0; i < 2; i++) if (a[i]) return i;
      return 0;
   endfunction

   assign obs = {alive, sel, sel_valid, sel_chg, edge_cnt, alive2, edge_cnt2};
   always_comb expv = {m_alive, 3'(m_sel), m_valid, m_chg, m_ec[1], m_ec[0], m_alive2, m_ec2[1], m_ec2[0]};

   initial begin
      for (int ch = 0; ch < 2; ch++) begin
         m_ec[ch] = '0; m_ec2[ch] = '0; run16[ch] = 0; run4[ch] = 0;
      end
      forever begin
         @(posedge local_clk);
         if (rst) begin
            m_pos = 0; m_prev = 2'b00; m_alive = 2'b00; m_alive2 = 2'b00;
            m_state = 0; m_sel = 0; m_valid = 1'b0; m_chg = 1'b0;
            foreach (wcnt[i, j]) wcnt[i][j] = 0;
            for (int ch = 0; ch < 2; ch++) begin
               m_ec[ch] = '0; m_ec2[ch] = '0; run16[ch] = 0; run4[ch] = 0;
            end
         end else begin
            m_pos++;
            m_chg = 1'b0;
            if (m_state == 0) begin
               if (m_alive != 2'b00) begin
                  m_sel = lowest(m_alive); m_chg = 1'b1; m_state = 2; g_exp = m_pos + GD;
               end
            end else if (m_state == 1 || m_pos == g_exp) begin
               if (m_alive == 2'b00) begin
                  m_chg = (m_sel != 0); m_sel = 0; m_state = 0; m_valid = 1'b0;
               end else if (lowest(m_alive) != m_sel) begin
                  m_sel = lowest(m_alive); m_chg = 1'b1; m_valid = 1'b0; m_state = 2; g_exp = m_pos + GD;
               end else begin
                  m_state = 1; m_valid = 1'b1;
               end
            end
            // a change sampled now is seen by the counter in the cycle at position m_pos+1
            for (int ch = 0; ch < 2; ch++)
               if (mon_tgl[ch] != m_prev[ch]) begin
                  if ((m_pos + 1) / WIN < 256) wcnt[(m_pos + 1) / WIN][ch]++;
                  m_prev[ch] = mon_tgl[ch];
               end
            if (m_pos % WIN == 0) begin
               for (int ch = 0; ch < 2; ch++) begin
                  int  c;
                  bit  g16, g4;
                  c = ((m_pos / WIN - 1) < 256) ? wcnt[m_pos / WIN - 1][ch] : 0;
                  m_ec[ch]  = (c > 65535) ? 16'hFFFF : 16'(c);
                  m_ec2[ch] = (c > 15) ? 4'hF : 4'(c);
                  g16 = (c >= MINE) && (c <= 65534);
                  g4  = (c >= MINE) && (c <= 14);
                  run16[ch] = g16 ? ((run16[ch] + 1 > GW) ? GW : run16[ch] + 1) : 0;
                  run4[ch]  = g4  ? ((run4[ch]  + 1 > GW) ? GW : run4[ch]  + 1) : 0;
                  m_alive[ch]  = (run16[ch] == GW);
                  m_alive2[ch] = (run4[ch] == GW);
               end
            end
         end
      end
   end

   // ---------------- stimulus: per-channel toggle generator ----------------
   int per [0:1] = '{0, 0};
   int jit [0:1] = '{0, 0};
   int tcnt [0:1] = '{0, 0};
   int cur [0:1] = '{0, 0};
   int inject_at = -1;

   initial forever begin
      @(posedge local_clk); #1;
      for (int ch = 0; ch < 2; ch++)
         if (per[ch] != 0) begin
            tcnt[ch]++;
            if (tcnt[ch] >= cur[ch]) begin
               mon_tgl[ch] = ~mon_tgl[ch];
               tcnt[ch] = 0;
               cur[ch] = per[ch] + int'($urandom_range(0, jit[ch]));
            end
         end
      if (!rst && m_pos == inject_at) mon_tgl[1] = ~mon_tgl[1];
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge local_clk);
      @(negedge local_clk);
      n_tests++;
      if (obs !== 49'd0) begin n_fail++; $display("FAIL reset_state got=%h exp=0", obs); end
      @(posedge local_clk); #1 rst = 1'b0;
   endtask

   task automatic test_single();
      int nchg = 0, chg_at = -1, valid_at = -1;
      per = '{20, 0}; jit = '{0, 0};
      for (int k = 0; k < 3 * WIN + 40; k++) begin
         @(negedge local_clk);
         n_tests++;
         if (obs !== expv) begin n_fail++; $display("FAIL single cyc=%0d got=%h exp=%h", k, obs, expv); end
         if (sel_chg) begin nchg++; chg_at = k; end
         if (chg_at >= 0 && valid_at < 0 && k > chg_at && sel_valid) valid_at = k;
      end
      n_tests++;
      if (nchg != 1 || valid_at - chg_at != GD) begin
         n_fail++; $display("FAIL single_guard pulses=%0d gap=%0d exp pulses=1 gap=%0d", nchg, valid_at - chg_at, GD);
      end
      n_tests++;
      if ({alive, sel, sel_valid} !== {2'b01, 3'd0, 1'b1}) begin
         n_fail++; $display("FAIL single_lock got alive=%b sel=%0d valid=%b exp 01/0/1", alive, sel, sel_valid);
      end
   endtask

   task automatic test_failover();
      int nchg = 0, chg_at = -1, valid_at = -1;
      per = '{20, 10 + int'($urandom_range(0, 15))}; jit = '{0, 3};
      for (int k = 0; k < 3 * WIN; k++) begin
         @(negedge local_clk);
         n_tests++;
         if (obs !== expv) begin n_fail++; $display("FAIL both cyc=%0d got=%h exp=%h", k, obs, expv); end
      end
      per[0] = 0;
      for (int k = 0; k < 2 * WIN + 40; k++) begin
         @(negedge local_clk);
         n_tests++;
         if (obs !== expv) begin n_fail++; $display("FAIL failover cyc=%0d got=%h exp=%h", k, obs, expv); end
         if (sel_chg) begin nchg++; chg_at = k; end
         if (chg_at >= 0 && valid_at < 0 && k > chg_at && sel_valid) valid_at = k;
      end
      n_tests++;
      if (nchg != 1 || valid_at - chg_at != GD || {alive, sel, sel_valid} !== {2'b10, 3'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL failover_end pulses=%0d gap=%0d alive=%b sel=%0d valid=%b exp 1/%0d/10/1/1",
                  nchg, valid_at - chg_at, alive, sel, sel_valid, GD);
      end
   endtask

   task automatic test_recover();
      int nchg = 0;
      per[0] = 20; jit[0] = 2;
      for (int k = 0; k < 3 * WIN + 40; k++) begin
         @(negedge local_clk);
         n_tests++;
         if (obs !== expv) begin n_fail++; $display("FAIL recover cyc=%0d got=%h exp=%h", k, obs, expv); end
         if (sel_chg) nchg++;
      end
      n_tests++;
      if (nchg != 1 || {alive, sel, sel_valid} !== {2'b11, 3'd0, 1'b1}) begin
         n_fail++; $display("FAIL recover_end pulses=%0d alive=%b sel=%0d valid=%b exp 1/11/0/1", nchg, alive, sel, sel_valid);
      end
   endtask

   task automatic test_saturate();
      per = '{1, 0}; jit = '{0, 0};
      for (int k = 0; k < 3 * WIN + 20; k++) begin
         @(negedge local_clk);
         n_tests++;
         if (obs !== expv) begin n_fail++; $display("FAIL saturate cyc=%0d got=%h exp=%h", k, obs, expv); end
      end
      n_tests++;
      if (edge_cnt2[3:0] !== 4'd15 || alive2[0] !== 1'b0 || edge_cnt[15:0] !== 16'd256) begin
         n_fail++; $display("FAIL saturate_end cnt4=%0d alive4=%b cnt16=%0d exp 15/0/256", edge_cnt2[3:0], alive2[0], edge_cnt[15:0]);
      end
      n_tests++;
      if ({sel2, sel_valid2, sel_chg2} !== 5'd0) begin
         n_fail++; $display("FAIL saturate_sel sel=%0d valid=%b chg=%b exp 0/0/0", sel2, sel_valid2, sel_chg2);
      end
   endtask

   task automatic test_last_edge();
      int w;
      per = '{0, 0};
      for (int k = 0; k < 2 * WIN + 20; k++) begin
         @(negedge local_clk);
         n_tests++;
         if (obs !== expv) begin n_fail++; $display("FAIL quiet cyc=%0d got=%h exp=%h", k, obs, expv); end
      end
      w = m_pos / WIN + 1;
      inject_at = w * WIN + WIN - 3;
      for (int k = 0; k < 3 * WIN && m_pos <= (w + 2) * WIN; k++) begin
         @(negedge local_clk);
         n_tests++;
         if (obs !== expv) begin n_fail++; $display("FAIL last_edge cyc=%0d got=%h exp=%h", k, obs, expv); end
         if (m_pos == (w + 1) * WIN) begin
            n_tests++;
            if (edge_cnt !== 32'h0001_0000) begin n_fail++; $display("FAIL last_edge_in got=%h exp=00010000", edge_cnt); end
         end
         if (m_pos == (w + 2) * WIN) begin
            n_tests++;
            if (edge_cnt !== 32'h0) begin n_fail++; $display("FAIL last_edge_carry got=%h exp=00000000", edge_cnt); end
         end
      end
      inject_at = -1;
   endtask

   task automatic test_reset_mid();
      int valid_at = -1;
      per = '{20, 0}; jit = '{0, 0};
      for (int k = 0; k < 3 * WIN + 40 + int'($urandom_range(10, 200)); k++) begin
         @(negedge local_clk);
         n_tests++;
         if (obs !== expv) begin n_fail++; $display("FAIL prelock cyc=%0d got=%h exp=%h", k, obs, expv); end
      end
      n_tests++;
      if (sel_valid !== 1'b1) begin n_fail++; $display("FAIL prelock_valid got=%b exp=1", sel_valid); end
      @(posedge local_clk); #1 rst = 1'b1;
      @(posedge local_clk); #1 rst = 1'b0;
      @(negedge local_clk);
      n_tests++;
      if (obs !== 49'd0) begin n_fail++; $display("FAIL reset_mid got=%h exp=0", obs); end
      for (int k = 1; k < 3 * WIN && valid_at < 0; k++) begin
         @(negedge local_clk);
         n_tests++;
         if (obs !== expv) begin n_fail++; $display("FAIL relock cyc=%0d got=%h exp=%h", k, obs, expv); end
         if (sel_valid) valid_at = k;
      end
      n_tests++;
      if (valid_at != 2 * WIN + GD + 1) begin
         n_fail++; $display("FAIL relock_time got=%0d exp=%0d", valid_at, 2 * WIN + GD + 1);
      end
   endtask

   task automatic test_back_to_back();
      for (int seg = 0; seg < 8; seg++) begin
         for (int ch = 0; ch < 2; ch++) begin
            case ($urandom_range(0, 3))
               0:       per[ch] = 0;
               1:       per[ch] = 1;
               default: per[ch] = int'($urandom_range(8, 64));
            endcase
            jit[ch] = int'($urandom_range(0, 5));
         end
         for (int k = 0; k < WIN + int'($urandom_range(0, 200)); k++) begin
            @(negedge local_clk);
            n_tests++;
            if (obs !== expv) begin n_fail++; $display("FAIL random seg=%0d cyc=%0d got=%h exp=%h", seg, k, obs, expv); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_failover();
      test_recover();
      test_saturate();
      test_last_edge();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
